imem_loader: RTL and testbench

//  Writer side of the instruction memory. It receives a program image as a

---
 rtl/imem_loader.sv | 103 ++++++++++
 tb/tb_imem_loader.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// imem_loader: loads a length-prefixed byte stream into instruction memory.
// It assembles big-endian 32-bit words and holds the CPU in reset until the image is complete.
// Ports:
//   clk, reset (async, active-high)
//   start            begin a new load (honoured in IDLE/DONE/ERR)
//   in_data/in_valid/in_ready   byte stream handshake
//   mem_we/mem_addr/mem_wd      instruction-memory write port (one-cycle strobe)
//   cpu_hold, done, err, words_loaded   status
module imem_loader #(
    parameter int ADDR_W    = 11,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wd,
    output logic              cpu_hold,
    output logic              done,
    output logic              err,
    output logic [15:0]       words_loaded
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_WRITE  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    logic [2:0]  state;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] words_next;
    logic [23:0] sh;
    logic [1:0]  cnt;

    assign in_ready   = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
    assign mem_we     = (state == S_WRITE);
    assign done       = (state == S_DONE);
    assign err        = (state == S_ERR);
    assign cpu_hold   = (state != S_DONE);
    assign len_full   = {len[15:8], in_data};
    assign words_next = words_loaded + 16'd1;

    // in_ready is 1 in every receive state, so in_valid alone marks a transfer there
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            len          <= '0;
            sh           <= '0;
            cnt          <= '0;
            mem_addr     <= '0;
            mem_wd       <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_LEN_HI;
                        words_loaded <= '0;
                        mem_addr     <= '0;
                        cnt          <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (in_valid) begin
                        len[15:8] <= in_data;
                        state     <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (in_valid) begin
                        len[7:0] <= in_data;
                        state    <= (len_full == 16'd0) ? S_DONE :
                                    (len_full > 16'(MAX_WORDS)) ? S_ERR : S_DATA;
                    end
                end
                S_DATA: begin
                    if (in_valid) begin
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'd3) begin
                            mem_wd <= {sh, in_data};
                            state  <= S_WRITE;
                        end else begin
                            sh <= {sh[15:0], in_data};
                        end
                    end
                end
                S_WRITE: begin
                    words_loaded <= words_next;
                    mem_addr     <= mem_addr + ADDR_W'(1);
                    state        <= (words_next == len) ? S_DONE : S_DATA;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed self-checking bench for imem_loader.
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [10:0] mem_addr;
    logic [31:0] mem_wd;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [15:0] words_loaded;

    int tests = 0;
    int fails = 0;
    int nw = 0;
    int base;
    logic [31:0] wd_log[64];
    logic [15:0] wa_log[64];

    imem_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd),
        .cpu_hold(cpu_hold), .done(done), .err(err), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we && nw < 64) begin
            wa_log[nw] <= 16'(mem_addr);
            wd_log[nw] <= mem_wd;
            nw <= nw + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit gap);
        int k = 0;
        if (gap) begin
            in_valid = 1'b0;
            tick();
        end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        send(w[31:24], gap);
        send(w[23:16], gap);
        send(w[15:8], gap);
        send(w[7:0], gap);
    endtask

    task automatic wait_end();
        int k = 0;
        while (!(done || err) && k < 20) begin
            tick();
            k++;
        end
    endtask

    initial begin
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("rst_done_err", {30'd0, done, err}, 32'd0);
        chk("rst_addr_wd", {21'd0, mem_addr} | mem_wd, 32'd0);
        chk("rst_words", {16'd0, words_loaded}, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle_ready", {31'd0, in_ready}, 32'd0);

        // Test 1: two-word image, valid held high
        base = nw;
        pulse_start();
        chk("t1_lenhi_ready", {31'd0, in_ready}, 32'd1);
        send(8'h00, 0);
        send(8'h02, 0);
        send_word(32'hDEADBEEF, 0);
        chk("t1_we_latency", {31'd0, mem_we}, 32'd1);
        chk("t1_wd_live", mem_wd, 32'hDEADBEEF);
        chk("t1_addr_live", {21'd0, mem_addr}, 32'd0);
        chk("t1_write_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t1_we_one_cycle", {31'd0, mem_we}, 32'd0);
        chk("t1_words_mid", {16'd0, words_loaded}, 32'd1);
        send_word(32'h0000002A, 0);
        wait_end();
        chk("t1_nwrites", nw - base, 32'd2);
        chk("t1_a0", {16'd0, wa_log[base]}, 32'd0);
        chk("t1_d0", wd_log[base], 32'hDEADBEEF);
        chk("t1_a1", {16'd0, wa_log[base+1]}, 32'd1);
        chk("t1_d1", wd_log[base+1], 32'h0000002A);
        chk("t1_done", {31'd0, done}, 32'd1);
        chk("t1_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("t1_words", {16'd0, words_loaded}, 32'd2);
        chk("t1_done_ready", {31'd0, in_ready}, 32'd0);

        // Test 2: zero-length header
        base = nw;
        pulse_start();
        chk("t2_restart_done", {31'd0, done}, 32'd0);
        send(8'h00, 0);
        send(8'h00, 0);
        wait_end();
        chk("t2_done", {31'd0, done}, 32'd1);
        chk("t2_nwrites", nw - base, 32'd0);
        chk("t2_words", {16'd0, words_loaded}, 32'd0);

        // Test 3: header 1025 -> error, then recovery
        base = nw;
        pulse_start();
        send(8'h04, 0);
        send(8'h01, 0);
        chk("t3_err", {31'd0, err}, 32'd1);
        chk("t3_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t3_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b1;
        tick();
        tick();
        in_valid = 1'b0;
        chk("t3_err_stays", {31'd0, err}, 32'd1);
        chk("t3_nwrites", nw - base, 32'd0);
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send_word(32'h11223344, 0);
        wait_end();
        chk("t3_recover_done", {30'd0, done, err}, 32'd2);
        chk("t3_recover_d", wd_log[base], 32'h11223344);

        // Boundary: exactly MAX_WORDS is legal
        pulse_start();
        send(8'h04, 0);
        send(8'h00, 0);
        chk("max_no_err", {31'd0, err}, 32'd0);
        chk("max_data_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        #1;
        chk("max_reset_ready", {31'd0, in_ready}, 32'd0);
        tick();
        reset = 1'b0;

        // Test 4: in_valid toggling across a 3-word image
        base = nw;
        pulse_start();
        send(8'h00, 1);
        send(8'h03, 1);
        send_word(32'h01020304, 1);
        send_word(32'hA5A5A5A5, 1);
        send_word(32'hFFFFFFFF, 1);
        wait_end();
        chk("t4_nwrites", nw - base, 32'd3);
        chk("t4_d0", wd_log[base], 32'h01020304);
        chk("t4_d1", wd_log[base+1], 32'hA5A5A5A5);
        chk("t4_a2", {16'd0, wa_log[base+2]}, 32'd2);
        chk("t4_d2", wd_log[base+2], 32'hFFFFFFFF);
        chk("t4_words", {16'd0, words_loaded}, 32'd3);

        // Test 5: asynchronous reset mid-word
        pulse_start();
        send(8'h00, 0);
        send(8'h04, 0);
        send_word(32'hCAFEF00D, 0);
        send(8'h12, 0);
        send(8'h34, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_ready", {31'd0, in_ready}, 32'd0);
        chk("t5_we", {31'd0, mem_we}, 32'd0);
        chk("t5_addr", {21'd0, mem_addr}, 32'd0);
        chk("t5_wd", mem_wd, 32'd0);
        chk("t5_cpu_hold", {31'd0, cpu_hold}, 32'd1);
        chk("t5_words", {16'd0, words_loaded}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        base = nw;
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send_word(32'h5566AABB, 0);
        wait_end();
        chk("t5_a0", {16'd0, wa_log[base]}, 32'd0);
        chk("t5_d0", wd_log[base], 32'h5566AABB);

        // Test 6: start ignored mid-DATA, honoured in DONE
        base = nw;
        pulse_start();
        send(8'h00, 0);
        send(8'h01, 0);
        send(8'hDE, 0);
        send(8'hAD, 0);
        pulse_start();
        chk("t6_still_data", {31'd0, in_ready}, 32'd1);
        send(8'hBE, 0);
        send(8'hEF, 0);
        wait_end();
        chk("t6_done", {31'd0, done}, 32'd1);
        chk("t6_nwrites", nw - base, 32'd1);
        chk("t6_d0", wd_log[base], 32'hDEADBEEF);
        pulse_start();
        chk("t6_hold_again", {31'd0, cpu_hold}, 32'd1);
        chk("t6_done_clr", {31'd0, done}, 32'd0);
        chk("t6_lenhi", {31'd0, in_ready}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
